// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - shared types and constants for the SPI register sequencer
// Contents:
//   state_e     frame sequencer states (IDLE, CMD, DATA, DONE)
//   CMD_WR_BIT  command bit selecting write (1) or read (0)
//   ADDR_W      register address width carried in the command byte
//   REG_W       register / SPI byte width
package spi_reg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int CMD_WR_BIT = 7;
  localparam int ADDR_W     = 3;
  localparam int REG_W      = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-stage synchronizer with rise/fall detection
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   din    in   asynchronous input
//   dout   out  synchronized level
//   rise   out  one-clk pulse on a synchronized 0->1 transition
//   fall   out  one-clk pulse on a synchronized 1->0 transition
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_reg_sequencer.sv
// rtl/spi_reg_sequencer.sv - SPI mode-0 slave decoding 16-bit frames into register accesses
// Ports:
//   clk        in   system clock (>= 4x sclk)
//   rst        in   asynchronous active-low reset
//   ss         in   chip select, active-low, asynchronous
//   sclk       in   SPI clock, idle low, asynchronous
//   mosi       in   SPI data in, MSB first
//   miso       out  SPI read data, MSB first; 0 when not returning read data
//   out        out  contents of register 0
//   wr_strobe  out  one-clk pulse when a mapped register is written
//   busy       out  high while a frame is in progress
module spi_reg_sequencer
  import spi_reg_pkg::*;
#(
  parameter int NREGS       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ss,
  input  logic             sclk,
  input  logic             mosi,
  output logic             miso,
  output logic [REG_W-1:0] out,
  output logic             wr_strobe,
  output logic             busy
);

  logic ss_s, sclk_s, mosi_s;
  logic sclk_rise, sclk_fall;
  logic ss_rise_unused, ss_fall_unused, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst_n(rst), .din(ss), .dout(ss_s),
    .rise(ss_rise_unused), .fall(ss_fall_unused)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst), .din(sclk), .dout(sclk_s),
    .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst), .din(mosi), .dout(mosi_s),
    .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_e             state_q, state_d;
  logic [2:0]         bit_cnt;
  logic [REG_W-2:0]   cmd_sr, dat_sr;
  logic [REG_W-1:0]   rd_sr;
  logic [ADDR_W-1:0]  addr_q;
  logic               is_wr_q;
  logic [REG_W-1:0]   regs [NREGS];

  // Byte as it stands including the bit arriving on this rise.
  logic [REG_W-1:0]   cmd_word, dat_word, rd_data;
  logic [ADDR_W-1:0]  cmd_addr;
  logic               last_bit;

  assign cmd_word = {cmd_sr, mosi_s};
  assign dat_word = {dat_sr, mosi_s};
  assign cmd_addr = cmd_word[ADDR_W-1:0];
  assign last_bit = sclk_rise && (bit_cnt == 3'd7);

  // Unmapped addresses read back as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (cmd_addr == ADDR_W'(i)) rd_data = regs[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ss_s) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = CMD;
        CMD:     if (last_bit) state_d = DATA;
        DATA:    if (last_bit) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt   <= '0;
      cmd_sr    <= '0;
      dat_sr    <= '0;
      rd_sr     <= '0;
      addr_q    <= '0;
      is_wr_q   <= 1'b0;
      wr_strobe <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      case (state_q)
        IDLE: begin
          bit_cnt <= '0;
          rd_sr   <= '0;
        end
        CMD: begin
          if (!ss_s && sclk_rise) begin
            cmd_sr  <= cmd_word[REG_W-2:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              is_wr_q <= cmd_word[CMD_WR_BIT];
              addr_q  <= cmd_addr;
              rd_sr   <= cmd_word[CMD_WR_BIT] ? '0 : rd_data;
            end
          end
        end
        DATA: begin
          if (!ss_s) begin
            if (sclk_rise) begin
              dat_sr  <= dat_word[REG_W-2:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7 && is_wr_q) begin
                for (int i = 0; i < NREGS; i++) begin
                  if (addr_q == ADDR_W'(i)) begin
                    regs[i]   <= dat_word;
                    wr_strobe <= 1'b1;
                  end
                end
              end
            end
            // The fall right after the command byte must keep the MSB that
            // was just loaded; shifting starts after the first data rise.
            if (sclk_fall && bit_cnt != 3'd0) rd_sr <= {rd_sr[REG_W-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  assign miso = (state_q == DATA) && !is_wr_q && rd_sr[REG_W-1];
  assign out  = regs[0];
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// tb/tb_spi_reg_sequencer.sv - randomized self-checking bench for spi_reg_sequencer
module tb_spi_reg_sequencer;

  localparam int S     = 2;
  localparam int NREGS = 4;

  logic       clk = 1'b0;
  logic       rst, ss, sclk, mosi;
  logic       miso, wr_strobe, busy;
  logic [7:0] out;

  spi_reg_sequencer #(.NREGS(NREGS), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .ss(ss), .sclk(sclk), .mosi(mosi),
    .miso(miso), .out(out), .wr_strobe(wr_strobe), .busy(busy)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int strobe_cnt = 0;
  int strobe_cyc = 0;
  int rise16_cyc = 0;
  logic [7:0] model [NREGS];

  always @(posedge clk) cyc = cyc + 1;
  always @(negedge clk) if (wr_strobe) begin
    strobe_cnt = strobe_cnt + 1;
    strobe_cyc = cyc;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic half();
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic ss_low();
    ss = 1'b0;
    half();
  endtask

  task automatic ss_high();
    sclk = 1'b0;
    half();
    ss = 1'b1;
    repeat (S + 2) @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [15:0] word, input int nbits,
                            output logic [15:0] rx, output logic extra_miso);
    rx = '0;
    extra_miso = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 16) ? word[15-i] : 1'($urandom);
      half();
      if (i < 16) rx[15-i] = miso;
      else        extra_miso = extra_miso | miso;
      sclk = 1'b1;
      if (i == 15) rise16_cyc = cyc;
      half();
      sclk = 1'b0;
    end
  endtask

  // Runs one frame of nbits (abort if < 16) plus extra ignored edges,
  // checks against the model and returns the read byte.
  task automatic do_frame(input logic [7:0] cmd, input logic [7:0] data,
                          input int nbits, input int extra, output logic [7:0] rd_byte);
    logic [15:0] rx, mask, exp_rx;
    logic        xm;
    logic [7:0]  rd;
    int          s0, exp_str;
    logic [2:0]  a;
    a = cmd[2:0];
    s0 = strobe_cnt;
    rd = (int'(a) < NREGS) ? model[a] : 8'h00;
    ss_low();
    check("busy_in_frame", busy, 1'b1);
    shift_bits({cmd, data}, nbits + extra, rx, xm);
    exp_str = 0;
    if (nbits >= 16 && cmd[7] && int'(a) < NREGS) begin
      model[a] = data;
      exp_str = 1;
    end
    ss_high();
    mask   = 16'(32'hFFFF_0000 >> nbits);
    exp_rx = cmd[7] ? 16'h0000 : {8'h00, rd};
    check("miso_bits", rx, exp_rx & mask);
    check("miso_done", xm, 1'b0);
    check("strobes", strobe_cnt - s0, exp_str);
    if (exp_str == 1) check("latency", strobe_cyc - rise16_cyc, S + 1);
    check("out", out, model[0]);
    check("busy_after", busy, 1'b0);
    rd_byte = rx[7:0];
  endtask

  initial begin
    logic [7:0] r;
    logic [15:0] rx;
    logic xm;
    int nb, ex;
    rst = 1'b0; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
    for (int i = 0; i < NREGS; i++) model[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", out, 8'h00);
    check("rst_miso", miso, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_strobe", wr_strobe, 1'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    do_frame(8'h80, 8'hA5, 16, 0, r);
    check("t1_out", out, 8'hA5);
    do_frame(8'h00, 8'h00, 16, 0, r);
    check("t2_read", r, 8'hA5);
    do_frame(8'h82, 8'h3C, 16, 0, r);
    do_frame(8'h02, 8'h00, 16, 0, r);
    check("t3_read", r, 8'h3C);
    check("t3_out", out, 8'hA5);
    do_frame(8'h85, 8'hFF, 16, 0, r);
    do_frame(8'h05, 8'h00, 16, 0, r);
    check("t4_read", r, 8'h00);
    do_frame(8'h80, 8'h11, 12, 0, r);
    check("t5_out", out, 8'hA5);
    do_frame(8'h01, 8'h00, 16, 0, r);
    check("t5_read", r, 8'h00);
    do_frame(8'h81, 8'h5A, 16, 24, r);

    ss_low();
    shift_bits(16'h8077, 12, rx, xm);
    rst = 1'b0;
    #1;
    check("t6_out", out, 8'h00);
    check("t6_miso", miso, 1'b0);
    check("t6_busy", busy, 1'b0);
    for (int i = 0; i < NREGS; i++) model[i] = 8'h00;
    ss = 1'b1; sclk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    do_frame(8'h03, 8'h00, 16, 0, r);
    check("t6_read_cleared", r, 8'h00);

    for (int k = 0; k < 40; k++) begin
      nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 15)) : 16;
      ex = (nb == 16) ? int'($urandom_range(0, 10)) : 0;
      do_frame({1'($urandom), 4'($urandom), 3'($urandom)}, 8'($urandom), nb, ex, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
